// File: rtl/reaction_ms_counter.sv
// Per-player reaction timer: gates the 1 ms tick generator and accumulates its pulses as 4-digit BCD.
// Optional auto-stop at TIMEOUT_MS when compiled with REACTION_TIMEOUT_EN.
module reaction_ms_counter #(
    parameter int TIMEOUT_MS = 9999
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        stop,
    input  logic        clear,
    input  logic        tick,
    output logic        timer_enable,
    output logic        timer_clear,
    output logic [15:0] bcd_ms,
    output logic        running,
    output logic        done,
    output logic        overflow
);

    typedef enum logic [1:0] {IDLE, RUN, HOLD, OVF} state_t;

    localparam logic [15:0] LIMIT_BCD = {4'(TIMEOUT_MS / 1000 % 10), 4'(TIMEOUT_MS / 100 % 10),
                                         4'(TIMEOUT_MS / 10 % 10),   4'(TIMEOUT_MS % 10)};
`ifdef REACTION_TIMEOUT_EN
    localparam logic TIMEOUT_EN = 1'b1;
`else
    localparam logic TIMEOUT_EN = 1'b0;
`endif

    state_t      state_q, state_d;
    logic [15:0] count_d;
    logic        clear_d;
    logic        at_limit;

    // Full ripple across all four digits in one cycle.
    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        carry;
        r     = v;
        carry = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (v[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    assign at_limit = TIMEOUT_EN && (bcd_ms == LIMIT_BCD);

    always_comb begin
        state_d = state_q;
        count_d = bcd_ms;
        clear_d = 1'b0;
        if (clear) begin
            state_d = IDLE;
            count_d = '0;
            clear_d = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_d = RUN;
                        count_d = '0;
                        clear_d = 1'b1;
                    end
                end
                RUN: begin
                    // A tick at the limit is never counted; stop wins over the overflow.
                    if (tick && !at_limit) count_d = bcd_inc(bcd_ms);
                    if (stop)                  state_d = HOLD;
                    else if (tick && at_limit) state_d = OVF;
                end
                default: ;
            endcase
        end
    end

`ifdef REACTION_TIMEOUT_EN
    logic overflow_q;
    assign overflow = overflow_q;
`else
    assign overflow = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            bcd_ms       <= '0;
            timer_clear  <= 1'b0;
            timer_enable <= 1'b0;
            running      <= 1'b0;
            done         <= 1'b0;
`ifdef REACTION_TIMEOUT_EN
            overflow_q   <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            bcd_ms       <= count_d;
            timer_clear  <= clear_d;
            timer_enable <= (state_d == RUN);
            running      <= (state_d == RUN);
            done         <= (state_d == HOLD);
`ifdef REACTION_TIMEOUT_EN
            overflow_q   <= (state_d == OVF);
`endif
        end
    end

endmodule

// File: tb/tb_reaction_ms_counter.sv
// Bench for reaction_ms_counter: directed scenarios plus random traffic against a decimal-count model.
module tb_reaction_ms_counter;

    localparam int TMO = 250;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0, stop = 1'b0, clear = 1'b0, tick = 1'b0;
    logic        timer_enable, timer_clear, running, done, overflow;
    logic [15:0] bcd_ms;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: phase 0 idle, 1 running, 2 holding, 3 overflowed; count kept as a plain integer.
    int m_phase = 0;
    int m_count = 0;
    bit m_tclr  = 1'b0;
`ifdef REACTION_TIMEOUT_EN
    bit timeout_on = 1'b1;
`else
    bit timeout_on = 1'b0;
`endif

    reaction_ms_counter #(.TIMEOUT_MS(TMO)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .clear(clear), .tick(tick),
        .timer_enable(timer_enable), .timer_clear(timer_clear), .bcd_ms(bcd_ms),
        .running(running), .done(done), .overflow(overflow)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_outputs();
        check_val("bcd_ms",       bcd_ms,               to_bcd(m_count));
        check_val("running",      16'(running),         16'(m_phase == 1));
        check_val("timer_enable", 16'(timer_enable),    16'(m_phase == 1));
        check_val("done",         16'(done),            16'(m_phase == 2));
        check_val("overflow",     16'(overflow),        16'(m_phase == 3));
        check_val("timer_clear",  16'(timer_clear),     16'(m_tclr));
    endtask

    task automatic model_reset();
        m_phase = 0;
        m_count = 0;
        m_tclr  = 1'b0;
    endtask

    task automatic model_step(input bit s, input bit p, input bit c, input bit t);
        m_tclr = c || (m_phase == 0 && s);
        if (c) begin
            m_phase = 0;
            m_count = 0;
        end else if (m_phase == 0) begin
            if (s) begin
                m_phase = 1;
                m_count = 0;
            end
        end else if (m_phase == 1) begin
            if (t && timeout_on && m_count == TMO) begin
                m_phase = p ? 2 : 3;
            end else begin
                if (t) m_count = (m_count + 1) % 10000;
                if (p) m_phase = 2;
            end
        end
    endtask

    // Called right after a falling edge; returns after the next falling edge.
    task automatic step(input bit s, input bit p, input bit c, input bit t);
        start = s; stop = p; clear = c; tick = t;
        @(posedge clk);
        model_step(s, p, c, t);
        #1;
        check_outputs();
        @(negedge clk);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 1);
    endtask

    task automatic restart();
        step(0, 0, 1, 0);
        step(1, 0, 0, 0);
    endtask

    initial begin
        #2;
        model_reset();
        check_outputs();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        step(1, 0, 0, 0);
        check_val("start_tclr", 16'(timer_clear), 16'h1);
        check_val("start_run",  16'(running), 16'h1);
        step(0, 0, 0, 0);
        check_val("tclr_one_cycle", 16'(timer_clear), 16'h0);
        ticks(37);
        check_val("count_37", bcd_ms, 16'h0037);
        ticks(62);
        check_val("count_99", bcd_ms, 16'h0099);
        step(0, 0, 0, 1);
        check_val("carry_100", bcd_ms, 16'h0100);
        step(0, 1, 0, 0);
        check_val("stop_done", 16'(done), 16'h1);
        check_val("stop_ten", 16'(timer_enable), 16'h0);
        ticks(5);
        step(1, 0, 0, 0);
        step(0, 1, 0, 1);
        check_val("hold_frozen", bcd_ms, 16'h0100);

        restart();
        ticks(512);
        step(0, 1, 0, 1);
        check_val("tick_stop_513", bcd_ms, 16'h0513);
        check_val("tick_stop_done", 16'(done), 16'h1);

        restart();
        ticks(20);
        step(0, 1, 1, 0);
        check_val("stop_clear_cnt", bcd_ms, 16'h0000);
        check_val("stop_clear_tclr", 16'(timer_clear), 16'h1);
        check_val("stop_clear_done", 16'(done), 16'h0);

`ifdef REACTION_TIMEOUT_EN
        restart();
        ticks(251);
        check_val("tmo_ovf", 16'(overflow), 16'h1);
        check_val("tmo_cnt", bcd_ms, 16'h0250);
        check_val("tmo_ten", 16'(timer_enable), 16'h0);
        restart();
        ticks(250);
        step(0, 1, 0, 1);
        check_val("tmo_stop_done", 16'(done), 16'h1);
        check_val("tmo_stop_ovf", 16'(overflow), 16'h0);
        check_val("tmo_stop_cnt", bcd_ms, 16'h0250);
`else
        restart();
        ticks(9999);
        check_val("cnt_9999", bcd_ms, 16'h9999);
        step(0, 0, 0, 1);
        check_val("wrap_cnt", bcd_ms, 16'h0000);
        check_val("wrap_run", 16'(running), 16'h1);
        check_val("wrap_ovf", 16'(overflow), 16'h0);
`endif

        restart();
        ticks(4321);
        check_val("pre_rst_cnt", bcd_ms, 16'h4321);
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        check_outputs();
        #1;
        rst = 1'b1;
        @(negedge clk);
        step(0, 0, 0, 0);
        step(1, 0, 0, 0);
        ticks(3);
        check_val("after_rst_cnt", bcd_ms, 16'h0003);

        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 9) == 0, $urandom_range(0, 19) == 0,
                 $urandom_range(0, 39) == 0, $urandom_range(0, 1) == 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/reaction_ms_counter.md
# reaction_ms_counter

Consumer side of the 1 ms tick interface: drives the tick generator's `enable`/`clear_time` controls and accumulates its `pulse` output into a 4-digit BCD millisecond count (0000–9999). Used by the game logic to time a player's reaction between a start event and that player's stop button. One instance per player; the outputs feed the score compare and the 7-segment display mux.

## Interface
- `TIMEOUT_MS`, default 9999: auto-stop limit in ms, legal range 1–9999. Only used when the timeout feature is compiled in.
- `clk`  in  1  system clock, 50 MHz.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  single-cycle start request from the game FSM.
- `stop`  in  1  single-cycle stop request, already debounced and edge-detected.
- `clear`  in  1  single-cycle return to idle, which zeros the count.
- `tick`  in  1  1 ms pulse from the tick generator; high for one cycle.
- `timer_enable`  out  1  drives the tick generator's `enable` input.
- `timer_clear`  out  1  drives the tick generator's `clear_time` input.
- `bcd_ms`  out  16  BCD count as {thousands, hundreds, tens, ones}.
- `running`  out  1  high while in state RUN.
- `done`  out  1  high while in state HOLD (result is valid).
- `overflow`  out  1  high while in state OVF.

## Operation
- FSM states: IDLE, RUN, HOLD, OVF. All outputs are registered.
- Reset (asynchronous, `rst`=0):
  - state goes to IDLE;
  - `bcd_ms`=16'h0000;
  - `timer_enable`=0, `timer_clear`=0, `running`=0, `done`=0, `overflow`=0.
- Priority when several requests arrive in the same cycle: `clear` > `stop` > `start`.
- `clear` in any state: go to IDLE, set `bcd_ms` to 0, pulse `timer_clear` for 1 cycle.
- IDLE + `start`: go to RUN, set `bcd_ms` to 0, pulse `timer_clear` for 1 cycle.
- `start` in RUN, HOLD or OVF is ignored.
- RUN + `tick`: BCD increment by one.
  - Ripple carry: a digit at 9 becomes 0 and carries into the next digit.
  - The whole increment completes in a single cycle.
- RUN + `stop`: go to HOLD.
  - If `tick` is high in the same cycle, that tick is counted first.
- HOLD and OVF hold `bcd_ms` frozen until `clear` arrives.
- `stop` outside RUN is ignored.
- `tick` outside RUN is ignored.
- `timer_enable` is 1 exactly when the registered state is RUN.

## Timing
- Latency from any request to the state change and outputs: 1 clock. The request is sampled at edge N; outputs are valid after edge N.
- `timer_clear` is high for exactly the one cycle after an accepted `start` or `clear`. It is also high on the first cycle `timer_enable` is high.
- `bcd_ms` updates on the clock edge after the `tick` cycle, so it lags the tick by 1 clock.
- The tick generator's first pulse arrives about 1 ms after `timer_enable` rises. The measured value is therefore floor(elapsed ms), with a resolution of 1 ms.
- Reset asserted mid-RUN: all outputs clear immediately, without waiting for `clk`. The block resumes in IDLE on the first clock edge after reset is released.

## Configuration
- Macro `REACTION_TIMEOUT_EN`.
- Defined:
  - In RUN, a `tick` arriving while `bcd_ms` equals BCD(`TIMEOUT_MS`) does not increment.
  - Instead, the FSM goes to OVF: `overflow`=1, `timer_enable`=0, and the count stays at BCD(`TIMEOUT_MS`).
  - A `stop` in the same cycle takes priority: the FSM goes to HOLD, the tick is not counted, and `overflow` stays 0.
- Undefined:
  - OVF is unreachable and `overflow` is tied to 0.
  - The count wraps from 9999 to 0000 and RUN continues.
  - `TIMEOUT_MS` is ignored.

## Test plan
- Reset, then release `rst`; pulse `start`. Expected sequence:
  - `timer_clear` is high for 1 cycle;
  - `running`=1 and `timer_enable`=1;
  - after 37 `tick` pulses, `bcd_ms`=16'h0037.
- Run to `bcd_ms`=16'h0099, then send 1 `tick` → 16'h0100, which checks the carry across two digits in a single cycle. Then pulse `stop` → `done`=1, `timer_enable`=0. Further ticks and `start` leave 16'h0100 unchanged.
- At count 16'h0512, assert `tick` and `stop` in the same cycle → HOLD with 16'h0513. At count 16'h0020, assert `stop` and `clear` together → IDLE with 16'h0000 and a `timer_clear` pulse.
- With `REACTION_TIMEOUT_EN` defined and `TIMEOUT_MS`=250: after 251 ticks → `overflow`=1, `bcd_ms`=16'h0250, `timer_enable`=0. A separate run reaches 16'h0250, then `tick` and `stop` in the same cycle → HOLD, `done`=1, `overflow`=0, 16'h0250. With the macro undefined: preset 16'h9999 and send 1 tick → 16'h0000, `running` still 1, `overflow`=0.
- Drop `rst` asynchronously in RUN at 16'h4321, between clock edges → all outputs go to 0 before the next edge. Release `rst`, pulse `start` → counting restarts from 0.
